// File: rtl/frogger_pkg.sv
// Shared types and screen constants for the frog sprite, ball and colour mapper.
package frogger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOP  = 2'd1,
        ST_DEAD = 2'd2,
        ST_OVER = 2'd3
    } frog_state_t;

    // Encoding matches the FrogDir output: 0 up, 1 left, 2 down, 3 right.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_RIGHT = 2'd3
    } frog_dir_t;

    localparam logic [15:0] KEY_W = 16'h001A;
    localparam logic [15:0] KEY_A = 16'h0004;
    localparam logic [15:0] KEY_S = 16'h0016;
    localparam logic [15:0] KEY_D = 16'h0007;

    localparam int unsigned SCR_X_START = 320;
    localparam int unsigned SCR_Y_START = 464;
    localparam int unsigned SCR_X_MIN   = 8;
    localparam int unsigned SCR_X_MAX   = 632;
    localparam int unsigned SCR_Y_MIN   = 16;
    localparam int unsigned SCR_Y_MAX   = 464;

endpackage

// File: rtl/frog_key_decoder.sv
// Turns the raw keycode stream into a one-frame press pulse plus a direction.
module frog_key_decoder
    import frogger_pkg::*;
(
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [15:0] keycode,
    output logic        press,
    output logic [1:0]  key_dir
);

    logic [15:0] r_prev_key;
    logic        w_valid;
    frog_dir_t   w_dir;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_prev_key <= '0;
        end else begin
            r_prev_key <= keycode;
        end
    end

    always_comb begin
        w_valid = 1'b1;
        w_dir   = DIR_UP;
        case (keycode)
            KEY_W:   w_dir = DIR_UP;
            KEY_A:   w_dir = DIR_LEFT;
            KEY_S:   w_dir = DIR_DOWN;
            KEY_D:   w_dir = DIR_RIGHT;
            default: w_valid = 1'b0;
        endcase
    end

    // Any change onto a direction key is a press, including key-to-key switches.
    assign press   = w_valid && (keycode != r_prev_key);
    assign key_dir = w_dir;

endmodule

// File: rtl/frog_hop_ctrl.sv
// Frog hop sequencer: press-to-hop grid moves, death freeze, lives, score, game over.
module frog_hop_ctrl
    import frogger_pkg::*;
#(
    parameter int unsigned X_START      = SCR_X_START,
    parameter int unsigned Y_START      = SCR_Y_START,
    parameter int unsigned X_MIN        = SCR_X_MIN,
    parameter int unsigned X_MAX        = SCR_X_MAX,
    parameter int unsigned Y_MIN        = SCR_Y_MIN,
    parameter int unsigned Y_MAX        = SCR_Y_MAX,
    parameter int unsigned HOP_DIST     = 16,
    parameter int unsigned HOP_FRAMES   = 4,
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned DEATH_FRAMES = 30
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [15:0] keycode,
    input  logic        hit,
    output logic [9:0]  FrogX,
    output logic [9:0]  FrogY,
    output logic [1:0]  FrogDir,
    output logic        hopping,
    output logic        dying,
    output logic [1:0]  lives,
    output logic [7:0]  score,
    output logic        game_over
);

    localparam int unsigned CW = (HOP_FRAMES > 1) ? $clog2(HOP_FRAMES) : 1;
    localparam int unsigned DW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

    localparam logic [10:0]   C_X_START = 11'(X_START);
    localparam logic [10:0]   C_Y_START = 11'(Y_START);
    localparam logic [10:0]   C_X_MIN   = 11'(X_MIN);
    localparam logic [10:0]   C_X_MAX   = 11'(X_MAX);
    localparam logic [10:0]   C_Y_MIN   = 11'(Y_MIN);
    localparam logic [10:0]   C_Y_MAX   = 11'(Y_MAX);
    localparam logic [10:0]   C_HOP     = 11'(HOP_DIST);
    localparam logic [10:0]   C_STEP    = 11'(HOP_DIST / HOP_FRAMES);
    localparam logic [CW-1:0] C_LAST    = CW'(HOP_FRAMES - 1);
    localparam logic [DW-1:0] C_DLOAD   = DW'(DEATH_FRAMES - 1);
    localparam logic [1:0]    C_LIVES   = 2'(LIVES_INIT);

    frog_state_t   r_state,    w_nxt_state;
    logic [10:0]   r_x,        w_nxt_x;
    logic [10:0]   r_y,        w_nxt_y;
    frog_dir_t     r_dir,      w_nxt_dir;
    frog_dir_t     r_hop_dir,  w_nxt_hop_dir;
    logic [CW-1:0] r_cnt,      w_nxt_cnt;
    logic [DW-1:0] r_death,    w_nxt_death;
    logic [1:0]    r_lives,    w_nxt_lives;
    logic [7:0]    r_score,    w_nxt_score;
    logic          r_pend_v,   w_nxt_pend_v;
    frog_dir_t     r_pend_dir, w_nxt_pend_dir;

    logic          w_press;
    logic [1:0]    w_key_raw;
    frog_dir_t     w_key_dir;
    logic [10:0]   w_step_x;
    logic [10:0]   w_step_y;
    logic          w_pend_v_eff;
    frog_dir_t     w_pend_dir_eff;

    frog_key_decoder u_keys (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .press     (w_press),
        .key_dir   (w_key_raw)
    );

    assign w_key_dir = frog_dir_t'(w_key_raw);

    // Lower-bound tests compare against MIN+HOP so no subtraction can underflow.
    function automatic logic f_legal(frog_dir_t d, logic [10:0] x, logic [10:0] y);
        case (d)
            DIR_UP:    return y >= (C_Y_MIN + C_HOP);
            DIR_LEFT:  return x >= (C_X_MIN + C_HOP);
            DIR_DOWN:  return (y + C_HOP) <= C_Y_MAX;
            DIR_RIGHT: return (x + C_HOP) <= C_X_MAX;
            default:   return 1'b0;
        endcase
    endfunction

    always_comb begin
        w_step_x = r_x;
        w_step_y = r_y;
        case (r_hop_dir)
            DIR_UP:    w_step_y = r_y - C_STEP;
            DIR_LEFT:  w_step_x = r_x - C_STEP;
            DIR_DOWN:  w_step_y = r_y + C_STEP;
            DIR_RIGHT: w_step_x = r_x + C_STEP;
            default: ;
        endcase
    end

    // A press on the completion edge itself is treated as the queued hop.
    assign w_pend_v_eff   = w_press || r_pend_v;
    assign w_pend_dir_eff = w_press ? w_key_dir : r_pend_dir;

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_x        = r_x;
        w_nxt_y        = r_y;
        w_nxt_dir      = r_dir;
        w_nxt_hop_dir  = r_hop_dir;
        w_nxt_cnt      = r_cnt;
        w_nxt_death    = r_death;
        w_nxt_lives    = r_lives;
        w_nxt_score    = r_score;
        w_nxt_pend_v   = r_pend_v;
        w_nxt_pend_dir = r_pend_dir;

        if (hit && (r_state == ST_IDLE || r_state == ST_HOP)) begin
            w_nxt_state  = ST_DEAD;
            w_nxt_death  = C_DLOAD;
            w_nxt_lives  = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
            w_nxt_pend_v = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        w_nxt_dir = w_key_dir;
                        if (f_legal(w_key_dir, r_x, r_y)) begin
                            w_nxt_state   = ST_HOP;
                            w_nxt_hop_dir = w_key_dir;
                            w_nxt_cnt     = '0;
                        end
                    end
                end
                ST_HOP: begin
                    if (w_press) begin
                        w_nxt_pend_v   = 1'b1;
                        w_nxt_pend_dir = w_key_dir;
                    end
                    w_nxt_x   = w_step_x;
                    w_nxt_y   = w_step_y;
                    w_nxt_cnt = r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        w_nxt_pend_v = 1'b0;
                        if (w_step_y == C_Y_MIN) begin
                            w_nxt_score = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                            w_nxt_x     = C_X_START;
                            w_nxt_y     = C_Y_START;
                            w_nxt_state = ST_IDLE;
                        end else if (w_pend_v_eff && f_legal(w_pend_dir_eff, w_step_x, w_step_y)) begin
                            w_nxt_state   = ST_HOP;
                            w_nxt_hop_dir = w_pend_dir_eff;
                            w_nxt_dir     = w_pend_dir_eff;
                            w_nxt_cnt     = '0;
                        end else begin
                            w_nxt_state = ST_IDLE;
                        end
                    end
                end
                ST_DEAD: begin
                    if (r_death == '0) begin
                        if (r_lives == 2'd0) begin
                            w_nxt_state = ST_OVER;
                        end else begin
                            w_nxt_x     = C_X_START;
                            w_nxt_y     = C_Y_START;
                            w_nxt_dir   = DIR_UP;
                            w_nxt_state = ST_IDLE;
                        end
                    end else begin
                        w_nxt_death = r_death - 1'b1;
                    end
                end
                ST_OVER: begin
                    if (w_press) begin
                        w_nxt_lives = C_LIVES;
                        w_nxt_score = '0;
                        w_nxt_x     = C_X_START;
                        w_nxt_y     = C_Y_START;
                        w_nxt_dir   = DIR_UP;
                        w_nxt_state = ST_IDLE;
                    end
                end
                default: w_nxt_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_x        <= C_X_START;
            r_y        <= C_Y_START;
            r_dir      <= DIR_UP;
            r_hop_dir  <= DIR_UP;
            r_cnt      <= '0;
            r_death    <= '0;
            r_lives    <= C_LIVES;
            r_score    <= '0;
            r_pend_v   <= 1'b0;
            r_pend_dir <= DIR_UP;
        end else begin
            r_state    <= w_nxt_state;
            r_x        <= w_nxt_x;
            r_y        <= w_nxt_y;
            r_dir      <= w_nxt_dir;
            r_hop_dir  <= w_nxt_hop_dir;
            r_cnt      <= w_nxt_cnt;
            r_death    <= w_nxt_death;
            r_lives    <= w_nxt_lives;
            r_score    <= w_nxt_score;
            r_pend_v   <= w_nxt_pend_v;
            r_pend_dir <= w_nxt_pend_dir;
        end
    end

    assign FrogX     = r_x[9:0];
    assign FrogY     = r_y[9:0];
    assign FrogDir   = r_dir;
    assign hopping   = (r_state == ST_HOP);
    assign dying     = (r_state == ST_DEAD);
    assign lives     = r_lives;
    assign score     = r_score;
    assign game_over = (r_state == ST_OVER);

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Self-checking bench for frog_hop_ctrl: vector table plus hand-written multi-frame sequences.
module tb_frog_hop_ctrl;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [15:0] keycode;
    logic        hit;
    logic [9:0]  FrogX, FrogY;
    logic [1:0]  FrogDir, lives;
    logic        hopping, dying, game_over;
    logic [7:0]  score;

    frog_hop_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .hit       (hit),
        .FrogX     (FrogX),
        .FrogY     (FrogY),
        .FrogDir   (FrogDir),
        .hopping   (hopping),
        .dying     (dying),
        .lives     (lives),
        .score     (score),
        .game_over (game_over)
    );

    always #5 frame_clk = ~frame_clk;

    localparam logic [15:0] KW = 16'h001A;
    localparam logic [15:0] KA = 16'h0004;
    localparam logic [15:0] KS = 16'h0016;
    localparam logic [15:0] KD = 16'h0007;
    localparam logic [15:0] K0 = 16'h0000;

    typedef struct {
        logic [15:0] key;
        logic        hit;
        logic [34:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [34:0] sb_q[$];
    string       nm_q[$];
    int          checks   = 0;
    int          failures = 0;

    // Bundle layout: x[34:25] y[24:15] dir[14:13] hop[12] dying[11] lives[10:9] score[8:1] over[0]
    function automatic logic [34:0] pk(int x, int y, int d, int hp, int dy, int lv, int sc, int ov);
        return {10'(x), 10'(y), 2'(d), 1'(hp), 1'(dy), 2'(lv), 8'(sc), 1'(ov)};
    endfunction

    function automatic logic [34:0] act();
        return {FrogX, FrogY, FrogDir, hopping, dying, lives, score, game_over};
    endfunction

    task automatic compare(string nm, logic [34:0] a, logic [34:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got x=%0d y=%0d dir=%0d hop=%0b dying=%0b lives=%0d score=%0d over=%0b; want x=%0d y=%0d dir=%0d hop=%0b dying=%0b lives=%0d score=%0d over=%0b",
                     nm, a[34:25], a[24:15], a[14:13], a[12], a[11], a[10:9], a[8:1], a[0],
                     e[34:25], e[24:15], e[14:13], e[12], e[11], e[10:9], e[8:1], e[0]);
        end
    endtask

    task automatic drive(logic [15:0] k, logic h, logic [34:0] e, string nm);
        keycode = k;
        hit     = h;
        sb_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge frame_clk);
        #1;
        compare(nm_q.pop_front(), act(), sb_q.pop_front());
    endtask

    initial begin
        // Illegal down hop at the bottom row, W held (single hop), then W with D queued mid-hop.
        tbl.push_back('{KS, 1'b0, pk(320, 464, 2, 0, 0, 3, 0, 0)});
        tbl.push_back('{K0, 1'b0, pk(320, 464, 2, 0, 0, 3, 0, 0)});
        tbl.push_back('{KW, 1'b0, pk(320, 464, 0, 1, 0, 3, 0, 0)});
        tbl.push_back('{KW, 1'b0, pk(320, 460, 0, 1, 0, 3, 0, 0)});
        tbl.push_back('{KW, 1'b0, pk(320, 456, 0, 1, 0, 3, 0, 0)});
        tbl.push_back('{KW, 1'b0, pk(320, 452, 0, 1, 0, 3, 0, 0)});
        tbl.push_back('{KW, 1'b0, pk(320, 448, 0, 0, 0, 3, 0, 0)});
        tbl.push_back('{KW, 1'b0, pk(320, 448, 0, 0, 0, 3, 0, 0)});
        tbl.push_back('{KW, 1'b0, pk(320, 448, 0, 0, 0, 3, 0, 0)});
        tbl.push_back('{K0, 1'b0, pk(320, 448, 0, 0, 0, 3, 0, 0)});
        tbl.push_back('{KW, 1'b0, pk(320, 448, 0, 1, 0, 3, 0, 0)});
        tbl.push_back('{KW, 1'b0, pk(320, 444, 0, 1, 0, 3, 0, 0)});
        tbl.push_back('{KD, 1'b0, pk(320, 440, 0, 1, 0, 3, 0, 0)});
        tbl.push_back('{KD, 1'b0, pk(320, 436, 0, 1, 0, 3, 0, 0)});
        tbl.push_back('{KD, 1'b0, pk(320, 432, 3, 1, 0, 3, 0, 0)});
        tbl.push_back('{KD, 1'b0, pk(324, 432, 3, 1, 0, 3, 0, 0)});
        tbl.push_back('{KD, 1'b0, pk(328, 432, 3, 1, 0, 3, 0, 0)});
        tbl.push_back('{KD, 1'b0, pk(332, 432, 3, 1, 0, 3, 0, 0)});
        tbl.push_back('{KD, 1'b0, pk(336, 432, 3, 0, 0, 3, 0, 0)});
        tbl.push_back('{K0, 1'b0, pk(336, 432, 3, 0, 0, 3, 0, 0)});

        Reset   = 1'b1;
        keycode = K0;
        hit     = 1'b0;
        #12;
        compare("reset_values", act(), pk(320, 464, 0, 0, 0, 3, 0, 0));
        @(posedge frame_clk);
        #1 Reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            drive(tbl[i].key, tbl[i].hit, tbl[i].exp, $sformatf("tbl%0d", i));

        // Climb from y=432 to the goal row; the final completion scores and respawns.
        for (int h = 0; h < 26; h++) begin
            int yb;
            yb = 432 - 16 * h;
            drive(KW, 1'b0, pk(336, yb, 0, 1, 0, 3, 0, 0), $sformatf("goal_acc%0d", h));
            for (int k = 1; k <= 4; k++) begin
                if (h == 25 && k == 4)
                    drive(KW, 1'b0, pk(320, 464, 0, 0, 0, 3, 1, 0), "goal_done");
                else
                    drive(KW, 1'b0, pk(336, yb - 4 * k, 0, (k < 4) ? 1 : 0, 0, 3, 0, 0),
                          $sformatf("goal_step%0d_%0d", h, k));
            end
            if (h == 25)
                drive(K0, 1'b0, pk(320, 464, 0, 0, 0, 3, 1, 0), "goal_idle");
            else
                drive(K0, 1'b0, pk(336, yb - 16, 0, 0, 0, 3, 0, 0), $sformatf("hop_idle%0d", h));
        end

        // Hop to 448, then a hit on the first step of the next hop freezes position.
        drive(KW, 1'b0, pk(320, 464, 0, 1, 0, 3, 1, 0), "pre_a");
        drive(KW, 1'b0, pk(320, 460, 0, 1, 0, 3, 1, 0), "pre_s1");
        drive(KW, 1'b0, pk(320, 456, 0, 1, 0, 3, 1, 0), "pre_s2");
        drive(KW, 1'b0, pk(320, 452, 0, 1, 0, 3, 1, 0), "pre_s3");
        drive(KW, 1'b0, pk(320, 448, 0, 0, 0, 3, 1, 0), "pre_s4");
        drive(K0, 1'b0, pk(320, 448, 0, 0, 0, 3, 1, 0), "pre_idle");
        drive(KW, 1'b0, pk(320, 448, 0, 1, 0, 3, 1, 0), "hit_acc");
        drive(KW, 1'b1, pk(320, 448, 0, 0, 1, 2, 1, 0), "hit_on_step");
        for (int i = 1; i < 30; i++)
            drive(K0, (i <= 5) ? 1'b1 : 1'b0, pk(320, 448, 0, 0, 1, 2, 1, 0), $sformatf("dead1_%0d", i));
        drive(K0, 1'b0, pk(320, 464, 0, 0, 0, 2, 1, 0), "respawn1");

        drive(K0, 1'b1, pk(320, 464, 0, 0, 1, 1, 1, 0), "hit2");
        for (int i = 1; i < 30; i++)
            drive(K0, 1'b0, pk(320, 464, 0, 0, 1, 1, 1, 0), $sformatf("dead2_%0d", i));
        drive(K0, 1'b0, pk(320, 464, 0, 0, 0, 1, 1, 0), "respawn2");

        drive(K0, 1'b1, pk(320, 464, 0, 0, 1, 0, 1, 0), "hit3");
        for (int i = 1; i < 30; i++)
            drive(K0, 1'b0, pk(320, 464, 0, 0, 1, 0, 1, 0), $sformatf("dead3_%0d", i));
        drive(K0, 1'b0, pk(320, 464, 0, 0, 0, 0, 1, 1), "game_over");
        drive(K0, 1'b1, pk(320, 464, 0, 0, 0, 0, 1, 1), "over_hit_ignored");
        drive(KA, 1'b0, pk(320, 464, 0, 0, 0, 3, 0, 0), "restart");
        drive(KA, 1'b0, pk(320, 464, 0, 0, 0, 3, 0, 0), "restart_no_hop");

        // Reset asserted between edges in the middle of a hop.
        drive(KW, 1'b0, pk(320, 464, 0, 1, 0, 3, 0, 0), "rst_acc");
        drive(KW, 1'b0, pk(320, 460, 0, 1, 0, 3, 0, 0), "rst_s1");
        #3 Reset = 1'b1;
        #1 compare("reset_mid_hop", act(), pk(320, 464, 0, 0, 0, 3, 0, 0));
        @(posedge frame_clk);
        #1 Reset = 1'b0;
        drive(KW, 1'b0, pk(320, 464, 0, 1, 0, 3, 0, 0), "post_reset_press");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
